muldiv_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers. It consumes the two register-file read operands (RD1 → a, RD2 → b) for MULT/MULTU/DIV/DIVU, and sources HI/LO data for MFHI/MFLO write-back into the register file. It raises busy so the control unit can stall issue while an operation runs.

---
 rtl/muldiv_unit_pkg.sv | 27 ++
 rtl/muldiv_unit_if.sv | 29 ++
 rtl/muldiv_unit_core.sv | 73 +++++++
 rtl/muldiv_unit.sv | 152 +++++++++++++++
 tb/tb_muldiv_unit.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - MDU_* : operation encodings carried on the 2-bit op field
//   - mdu_state_e : FSM states of muldiv_unit (IDLE -> CALC -> FIX -> IDLE)
//   - op_is_div / op_is_signed : decode helpers for the op field
package cpu_defs;

    localparam logic [1:0] MDU_MULT  = 2'd0;
    localparam logic [1:0] MDU_MULTU = 2'd1;
    localparam logic [1:0] MDU_DIV   = 2'd2;
    localparam logic [1:0] MDU_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

    // Bit 1 selects divide, bit 0 selects unsigned.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Handshake/data bundle between the CPU control/datapath and muldiv_unit.
//   cpu  modport : drives start/op/a/b/hi_we/lo_we/wd, observes busy/done/hi/lo
//   unit modport : the multiply/divide unit side
// master = cpu side, slave = unit side.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wd;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wd,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wd,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit_core.sv
// Iteration datapath for muldiv_unit: one radix-2 step per 'step' cycle.
//   clk, rst   : clock, async active-high reset
//   load       : seed accumulator with {0, init_lo}, latch opnd, counter=WIDTH-1
//   step       : perform one multiply or divide step, decrement counter
//   is_div     : step type (0 shift-add multiply, 1 restoring divide)
//   init_lo    : multiplier (multiply) or dividend (divide) magnitude
//   opnd       : multiplicand (multiply) or divisor (divide) magnitude
//   acc        : raw result; multiply = 2*WIDTH product,
//                divide = {remainder, quotient}
//   last       : counter has reached zero (this step is the final one)
module muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   init_lo,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc,
    output logic               last
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [CW-1:0]      cnt_q;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;

    // Multiply: multiplier sits in the low half and is consumed LSB first;
    // the carry of the add becomes the new top bit after the right shift.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    end

    // Divide: high half is the partial remainder, low half shifts the
    // dividend out MSB first and collects quotient bits at the bottom.
    // Remainder stays below the divisor, so {rem, bit} fits in WIDTH+1 bits.
    always_comb begin
        div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
        if (!div_trial[WIDTH])
            div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else
            div_next = {acc_q[2*WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            acc_q  <= {{WIDTH{1'b0}}, init_lo};
            opnd_q <= opnd;
            cnt_q  <= CW'(WIDTH - 1);
        end else if (step) begin
            acc_q <= is_div ? div_next : mul_next;
            if (cnt_q != '0)
                cnt_q <= cnt_q - 1'b1;
        end
    end

    assign acc  = acc_q;
    assign last = (cnt_q == '0);

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
//   clk, rst : clock, async active-high reset (discards any op in flight)
//   bus      : muldiv_unit_if slave side
//     start/op/a/b : launch MULT/MULTU/DIV/DIVU, sampled only in IDLE
//     hi_we/lo_we/wd : MTHI/MTLO writes, honoured only in IDLE without start
//     busy : state != IDLE
//     done : one-cycle pulse when HI/LO carry a fresh result
//     hi/lo : HI/LO registers
// Sequence: start edge -> WIDTH CALC steps -> one FIX edge writes HI/LO.
module muldiv_unit
    import cpu_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    muldiv_unit_if.slave    bus
);
    mdu_state_e state_q, state_d;

    logic [1:0]       op_q;
    logic             sa_q, sb_q;
    logic             bzero_q;
    logic [WIDTH-1:0] a_raw_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q;

    logic             core_load, core_step, core_last;
    logic [2*WIDTH-1:0] core_acc;

    logic             sa_in, sb_in;
    logic [WIDTH-1:0] a_mag, b_mag;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    // Magnitudes: -0x80..0 wraps to 0x80..0, which is the right unsigned
    // magnitude, so no extra bit is needed.
    always_comb begin
        sa_in = op_is_signed(bus.op) & bus.a[WIDTH-1];
        sb_in = op_is_signed(bus.op) & bus.b[WIDTH-1];
        a_mag = sa_in ? (~bus.a + 1'b1) : bus.a;
        b_mag = sb_in ? (~bus.b + 1'b1) : bus.b;
    end

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (core_load),
        .step    (core_step),
        .is_div  (op_is_div(state_q == ST_IDLE ? bus.op : op_q)),
        .init_lo (op_is_div(bus.op) ? a_mag : b_mag),
        .opnd    (op_is_div(bus.op) ? b_mag : a_mag),
        .acc     (core_acc),
        .last    (core_last)
    );

    // Next state / core controls
    always_comb begin
        state_d   = state_q;
        core_load = 1'b0;
        core_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    core_load = 1'b1;
                    state_d   = ST_CALC;
                end
            end
            ST_CALC: begin
                core_step = 1'b1;
                if (core_last)
                    state_d = ST_FIX;
            end
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= MDU_MULT;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bzero_q <= 1'b0;
            a_raw_q <= '0;
        end else if (core_load) begin
            op_q    <= bus.op;
            sa_q    <= sa_in;
            sb_q    <= sb_in;
            bzero_q <= (bus.b == '0);
            a_raw_q <= bus.a;
        end
    end

    // Sign correction of the raw core result
    always_comb begin
        prod = core_acc;
        if (sa_q ^ sb_q)
            prod = ~core_acc + 1'b1;

        quot = core_acc[WIDTH-1:0];
        rem  = core_acc[2*WIDTH-1:WIDTH];
        if (sa_q ^ sb_q)
            quot = ~core_acc[WIDTH-1:0] + 1'b1;
        if (sa_q)
            rem = ~core_acc[2*WIDTH-1:WIDTH] + 1'b1;

        if (!op_is_div(op_q)) begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end else if (bzero_q) begin
            // Divide by zero bypasses the sign fix and returns raw a.
            fix_hi = a_raw_q;
            fix_lo = '1;
        end else begin
            fix_hi = rem;
            fix_lo = quot;
        end
    end

    // HI/LO: result write in FIX wins; MT* writes only in IDLE and only
    // when no start is being accepted that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == ST_FIX);
            if (state_q == ST_FIX) begin
                hi_q <= fix_hi;
                lo_q <= fix_lo;
            end else if (state_q == ST_IDLE && !bus.start) begin
                if (bus.hi_we) hi_q <= bus.wd;
                if (bus.lo_we) lo_q <= bus.wd;
            end
        end
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a vector table of single operations with
// hand-computed HI/LO plus sequences for MT* writes, start-while-busy and
// asynchronous reset mid-operation.
module tb_muldiv_unit;
    import cpu_defs::*;

    localparam int W = 32;
    localparam int DONE_EDGE = W + 1;   // edges after the start edge

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vecs[$];

    // Launch one op and follow it to its done pulse. If inj_at > 0, a second
    // start plus hi_we are asserted for one cycle at that edge count.
    task automatic run_op(input string name, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inj_at);
        int done_at;
        logic busy_ok;
        done_at = -1;
        busy_ok = 1'b1;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) busy_ok = 1'b0;
        for (int n = 1; n <= DONE_EDGE + 8; n++) begin
            @(posedge clk);
            #1;
            if (inj_at > 0 && n == inj_at) begin
                bus.start = 1'b1; bus.op = MDU_DIVU; bus.a = 9; bus.b = 3;
                bus.hi_we = 1'b1; bus.wd = 32'hDEADBEEF;
            end
            if (inj_at > 0 && n == inj_at + 1) begin
                bus.start = 1'b0; bus.hi_we = 1'b0;
            end
            if (bus.done === 1'b1) begin
                done_at = n;
                break;
            end
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
        end
        chk({name, " done edge"}, 64'(done_at), 64'(DONE_EDGE));
        chk({name, " busy while running"}, {63'd0, busy_ok}, 64'd1);
        if (done_at > 0) begin
            chk({name, " busy low at done"}, {63'd0, bus.busy}, 64'd0);
        end
    endtask

    task automatic check_pulse_end(input string name);
        @(posedge clk);
        #1;
        chk({name, " done single pulse"}, {63'd0, bus.done}, 64'd0);
    endtask

    logic [W-1:0] lo_keep;
    int late_done;

    initial begin
        bus.start = 1'b0; bus.op = MDU_MULT; bus.a = '0; bus.b = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wd = '0;

        vecs.push_back('{"multu_max",  MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
        vecs.push_back('{"mult_neg",   MDU_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB});
        vecs.push_back('{"div_neg",    MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD});
        vecs.push_back('{"div_negb",   MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD});
        vecs.push_back('{"divu_100_7", MDU_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E});
        vecs.push_back('{"divu_by0",   MDU_DIVU,  32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF});
        vecs.push_back('{"div_by0neg", MDU_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF});
        vecs.push_back('{"mult_minsq", MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
        vecs.push_back('{"multu_3x4",  MDU_MULTU, 32'd3,        32'd4,        32'h00000000, 32'h0000000C});
        vecs.push_back('{"div_ovf",    MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});

        // Reset state
        #12;
        chk("reset busy", {63'd0, bus.busy}, 64'd0);
        chk("reset done", {63'd0, bus.done}, 64'd0);
        chk("reset hi",   64'(bus.hi), 64'd0);
        chk("reset lo",   64'(bus.lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, 0);
            chk({vecs[i].name, " hi"}, 64'(bus.hi), 64'(vecs[i].hi));
            chk({vecs[i].name, " lo"}, 64'(bus.lo), 64'(vecs[i].lo));
            check_pulse_end(vecs[i].name);
            chk({vecs[i].name, " hi held"}, 64'(bus.hi), 64'(vecs[i].hi));
        end

        // MTHI after the overflow divide: HI changes, LO kept
        @(negedge clk);
        bus.hi_we = 1'b1; bus.wd = 32'h12345678;
        @(posedge clk); #1;
        bus.hi_we = 1'b0;
        chk("mthi hi", 64'(bus.hi), 64'h12345678);
        chk("mthi lo", 64'(bus.lo), 64'h80000000);

        // MTHI+MTLO together
        @(negedge clk);
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wd = 32'hA5A5_0F0F;
        @(posedge clk); #1;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        chk("mt both hi", 64'(bus.hi), 64'hA5A50F0F);
        chk("mt both lo", 64'(bus.lo), 64'hA5A50F0F);

        // Start and MTLO in the same IDLE cycle: start wins
        @(negedge clk);
        bus.start = 1'b1; bus.op = MDU_MULTU; bus.a = 32'd6; bus.b = 32'd7;
        bus.lo_we = 1'b1; bus.wd = 32'h0BAD0BAD;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.lo_we = 1'b0;
        chk("start vs mtlo lo", 64'(bus.lo), 64'hA5A50F0F);
        chk("start vs mtlo busy", {63'd0, bus.busy}, 64'd1);
        late_done = -1;
        for (int n = 1; n <= DONE_EDGE + 8; n++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin late_done = n; break; end
        end
        chk("start vs mtlo done edge", 64'(late_done), 64'(DONE_EDGE));
        chk("start vs mtlo result", 64'(bus.lo), 64'd42);

        // start + hi_we while busy are ignored
        run_op("busy_ignore", MDU_MULTU, 32'd3, 32'd4, 5);
        chk("busy_ignore hi", 64'(bus.hi), 64'd0);
        chk("busy_ignore lo", 64'(bus.lo), 64'd12);
        check_pulse_end("busy_ignore");
        chk("busy_ignore idle", {63'd0, bus.busy}, 64'd0);

        // Async reset in the middle of CALC
        @(negedge clk);
        bus.start = 1'b1; bus.op = MDU_MULTU; bus.a = 32'd5; bus.b = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("mid rst busy", {63'd0, bus.busy}, 64'd0);
        chk("mid rst done", {63'd0, bus.done}, 64'd0);
        chk("mid rst hi",   64'(bus.hi), 64'd0);
        chk("mid rst lo",   64'(bus.lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        late_done = 0;
        for (int n = 0; n < DONE_EDGE + 10; n++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) late_done++;
        end
        chk("no done after rst", 64'(late_done), 64'd0);
        chk("lo after rst", 64'(bus.lo), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
